// File: rtl/galvano_pkg.sv
// galvano_pkg: shared state encoding, default widths and magnitude helper
package galvano_pkg;
  localparam int POS_W_D = 16;
  localparam int CNT_W_D = 16;
  typedef enum logic [2:0] {IDLE, RAMP, SETTLE, HOLD, FAULT} state_e;
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/pos_target_sequencer_if.sv
// pos_target_sequencer_if: command, configuration, ADC and target signals of the sequencer
interface pos_target_sequencer_if #(parameter int POS_W = 16, parameter int CNT_W = 16);
  logic             cmd_valid;
  logic [POS_W-1:0] cmd_target;
  logic [POS_W-1:0] slew_step;
  logic [POS_W-1:0] settle_window;
  logic [CNT_W-1:0] settle_count;
  logic [CNT_W-1:0] timeout_samples;
  logic             pos_adc_data_valid;
  logic [POS_W-1:0] pos_adc;
  logic [POS_W-1:0] pid_target;
  logic             pid_target_valid;
  logic             busy;
  logic             settled;
  logic             fault;
  modport master (output cmd_valid, cmd_target, slew_step, settle_window, settle_count,
                  timeout_samples, pos_adc_data_valid, pos_adc,
                  input pid_target, pid_target_valid, busy, settled, fault);
  modport slave (input cmd_valid, cmd_target, slew_step, settle_window, settle_count,
                 timeout_samples, pos_adc_data_valid, pos_adc,
                 output pid_target, pid_target_valid, busy, settled, fault);
endinterface

// File: rtl/pos_settle_detector.sv
// pos_settle_detector: saturating in-window and timeout sample counters with hit flags
module pos_settle_detector import galvano_pkg::*; #(
  parameter int POS_W = POS_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk_pid,
  input  logic             sys_rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [POS_W-1:0] pos_i,
  input  logic [POS_W-1:0] final_i,
  input  logic [POS_W-1:0] window_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic             in_win_o,
  output logic             settle_hit_o,
  output logic             timeout_hit_o
);
  logic [CNT_W-1:0] in_q, in_d, to_q, to_d, need;
  logic [31:0]      err;
  // hits look at the post-sample count so the deciding sample itself is counted
  always_comb begin
    err           = abs_diff(32'(pos_i), 32'(final_i));
    in_win_o      = err <= 32'(window_i);
    in_d          = in_win_o ? (&in_q ? in_q : in_q + CNT_W'(1)) : '0;
    to_d          = &to_q ? to_q : to_q + CNT_W'(1);
    need          = count_i == '0 ? CNT_W'(1) : count_i;
    settle_hit_o  = en_i && in_d >= need;
    timeout_hit_o = en_i && timeout_i != '0 && to_d >= timeout_i;
  end
  always_ff @(posedge clk_pid or posedge sys_rst) begin
    if (sys_rst) begin
      in_q <= '0;
      to_q <= '0;
    end else if (clr_i) begin
      in_q <= '0;
      to_q <= '0;
    end else if (en_i) begin
      in_q <= in_d;
      to_q <= to_d;
    end
  end
endmodule

// File: rtl/pos_target_sequencer.sv
// pos_target_sequencer: slews the PID target toward a commanded final position and supervises settling
module pos_target_sequencer import galvano_pkg::*; #(
  parameter int POS_W = POS_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input logic clk_pid,
  input logic sys_rst,
  pos_target_sequencer_if.slave bus
);
  state_e           state_q, state_d;
  logic [POS_W-1:0] final_q, final_d, tgt_q, tgt_d;
  logic             tv_q, tv_d, valid_q, busy_q, settled_q, fault_q;
  logic             evt, en, clr, in_win, settle_hit, timeout_hit;
  logic [31:0]      mag;
  assign evt = bus.pos_adc_data_valid & ~valid_q;
  pos_settle_detector #(.POS_W(POS_W), .CNT_W(CNT_W)) u_det (
    .clk_pid       (clk_pid),
    .sys_rst       (sys_rst),
    .en_i          (en),
    .clr_i         (clr),
    .pos_i         (bus.pos_adc),
    .final_i       (final_q),
    .window_i      (bus.settle_window),
    .count_i       (bus.settle_count),
    .timeout_i     (bus.timeout_samples),
    .in_win_o      (in_win),
    .settle_hit_o  (settle_hit),
    .timeout_hit_o (timeout_hit)
  );
  // a command always wins over a coincident sample, which is then dropped
  always_comb begin
    state_d = state_q;
    final_d = final_q;
    tgt_d   = tgt_q;
    tv_d    = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    mag     = abs_diff(32'(final_q), 32'(tgt_q));
    if (bus.cmd_valid) begin
      final_d = bus.cmd_target;
      clr     = 1'b1;
      state_d = RAMP;
    end else if (evt) begin
      case (state_q)
        RAMP: begin
          tv_d = 1'b1;
          if (bus.slew_step == '0 || mag <= 32'(bus.slew_step)) begin
            tgt_d   = final_q;
            state_d = SETTLE;
          end else begin
            tgt_d = final_q > tgt_q ? tgt_q + bus.slew_step : tgt_q - bus.slew_step;
          end
        end
        SETTLE: begin
          en      = 1'b1;
          state_d = settle_hit ? HOLD : timeout_hit ? FAULT : SETTLE;
        end
        HOLD: begin
          clr     = ~in_win;
          state_d = in_win ? HOLD : SETTLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_pid or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      final_q   <= '0;
      tgt_q     <= '0;
      tv_q      <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      final_q   <= final_d;
      tgt_q     <= tgt_d;
      tv_q      <= tv_d;
      valid_q   <= bus.pos_adc_data_valid;
      busy_q    <= state_d == RAMP || state_d == SETTLE;
      settled_q <= state_d == HOLD;
      fault_q   <= state_d == FAULT;
    end
  end
  assign bus.pid_target       = tgt_q;
  assign bus.pid_target_valid = tv_q;
  assign bus.busy             = busy_q;
  assign bus.settled          = settled_q;
  assign bus.fault            = fault_q;
endmodule
